// File: rtl/divider_32bit.sv
// divider_32bit: multi-cycle unsigned 32-bit restoring divider.
// One quotient bit is produced per clock. Each trial subtraction goes through
// a 32-bit carry-lookahead adder fed with the inverted divisor and carry-in 1,
// so the adder carry-out doubles as the "no borrow" flag.

module cla_adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] gen_s;
  logic [31:0] prop_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // Lookahead carries inside a 4-bit group: returns {c4, c3, c2, c1}.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Chain eight lookahead groups; each group's carry-out feeds the next group.
  always_comb begin : carry_chain
    logic       grp_c_s;
    logic [3:0] grp_out_s;
    sum       = 32'd0;
    grp_c_s   = cin;
    grp_out_s = 4'd0;
    for (int k = 0; k < 8; k++) begin
      grp_out_s        = cla4(gen_s[4*k +: 4], prop_s[4*k +: 4], grp_c_s);
      sum[4*k +: 4]    = prop_s[4*k +: 4] ^ {grp_out_s[2:0], grp_c_s};
      grp_c_s          = grp_out_s[3];
    end
    cout = grp_c_s;
  end

endmodule

module divider_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] q_r, q_s;
  logic [31:0] d_r, d_s;
  logic [32:0] r_r, r_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [31:0] quotient_r, quotient_s;
  logic [31:0] remainder_r, remainder_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        dbz_r, dbz_s;

  logic [32:0] part_s;
  logic [31:0] diff_s;
  logic        carry_s;
  logic        take_s;

  // Shift the next dividend bit into the partial remainder.
  assign part_s = {r_r[31:0], q_r[31]};

  cla_adder_32 u_sub (
    .a    (part_s[31:0]),
    .b    (~d_r),
    .cin  (1'b1),
    .sum  (diff_s),
    .cout (carry_s)
  );

  // A set bit 32 means the shifted remainder already exceeds any 32-bit divisor.
  assign take_s = part_s[32] | carry_s;

  // Next-state, datapath and output decode.
  always_comb begin
    state_s     = state_r;
    q_s         = q_r;
    d_s         = d_r;
    r_s         = r_r;
    cnt_s       = cnt_r;
    quotient_s  = quotient_r;
    remainder_s = remainder_r;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    dbz_s       = dbz_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          q_s   = dividend;
          d_s   = divisor;
          r_s   = 33'd0;
          cnt_s = 5'd0;
          dbz_s = 1'b0;
          if (divisor == 32'd0) begin
            state_s     = ST_DONE;
            done_s      = 1'b1;
            dbz_s       = 1'b1;
            quotient_s  = 32'hFFFF_FFFF;
            remainder_s = dividend;
          end else begin
            state_s = ST_RUN;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        q_s   = {q_r[30:0], take_s};
        r_s   = take_s ? {1'b0, diff_s} : part_s;
        cnt_s = cnt_r + 5'd1;
        if (cnt_r == 5'd31) begin
          state_s     = ST_DONE;
          done_s      = 1'b1;
          quotient_s  = {q_r[30:0], take_s};
          remainder_s = take_s ? diff_s : part_s[31:0];
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r         <= 32'd0;
      d_r         <= 32'd0;
      r_r         <= 33'd0;
      cnt_r       <= 5'd0;
      quotient_r  <= 32'd0;
      remainder_r <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      q_r         <= q_s;
      d_r         <= d_s;
      r_r         <= r_s;
      cnt_r       <= cnt_s;
      quotient_r  <= quotient_s;
      remainder_r <= remainder_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      dbz_r       <= dbz_s;
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_divider_32bit.sv
// Scoreboard bench for divider_32bit: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever done is presented.
module tb_divider_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  divider_32bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending result");
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.z});
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                       input logic [31:0] er, input logic ez, input logic push);
    exp_t t;
    t.q = eq;
    t.r = er;
    t.z = ez;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back(t);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the start edge until done; optionally pulses a stray start.
  task automatic wait_done(input int exp_lat, input logic exp_busy0, input int pulse_at, input string nm);
    int   k;
    logic seen;
    k    = 0;
    seen = 1'b0;
    @(negedge clk);
    check({nm, "_busy_first"}, {31'd0, busy}, {31'd0, exp_busy0});
    while (k < 40 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (k == pulse_at) begin
          start    = 1'b1;
          dividend = 32'd7;
          divisor  = 32'd2;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    check({nm, "_latency"}, k, exp_lat);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic ez, input int lat,
                         input logic busy0, input string nm);
    issue(a, b, eq, er, ez, 1'b1);
    wait_done(lat, busy0, -1, nm);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_done;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 1'b1, "d100_7");
    run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 1'b1, "max_by_1");
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32, 1'b1, "max_by_max");
    run_div(32'hFFFF_FFFE, 32'h8000_0001, 32'd1, 32'h7FFF_FFFD, 1'b0, 32, 1'b1, "s32_case");
    run_div(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 32, 1'b1, "d3_10");
    run_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 1'b0, "by_zero");
    check("dbz_held", {31'd0, div_by_zero}, 32'd1);
    check("dbz_quotient_held", quotient, 32'hFFFF_FFFF);
    check("dbz_busy_low", {31'd0, busy}, 32'd0);

    // Stray start mid-run is ignored; start in DONE is accepted back-to-back.
    issue(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1);
    wait_done(32, 1'b1, 5, "ignore_start");
    issue(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b1);
    wait_done(32, 1'b1, -1, "back_to_back");
    @(negedge clk);

    // Reset mid-run aborts without a done pulse.
    issue(32'd1000, 32'd10, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("no_done_after_reset", {31'd0, seen_done}, 32'd0);
    run_div(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 32, 1'b1, "d9_4");
    repeat (3) @(negedge clk);
    check("quotient_hold", quotient, 32'd2);
    check("remainder_hold", remainder, 32'd1);
    check("done_pulse_only", {31'd0, done}, 32'd0);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
